// File: rtl/common_pkg.sv
// Shared types for the scheduler blocks.
//   sched_state_t : arbitration state, IDLE between packets, LOCKED while a
//                   multi-beat packet owns the mux.
package common_pkg;

  typedef enum logic {IDLE, LOCKED} sched_state_t;

endpackage

// File: rtl/mux_rr_sched_if.sv
// Bundle of requester-side and consumer-side signals of mux_rr_sched.
//   i_req_vld/i_req_data/i_req_last/o_req_rdy : N requester beat handshakes
//   o_y_vld/o_y_data/o_y_last/o_y_src/i_y_rdy : registered output beat handshake
//   o_busy                                   : packet in progress or beat pending
// slave  : the scheduler side
// master : the environment side (requesters plus downstream consumer)
interface mux_rr_sched_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
);

  logic [N-1:0]        i_req_vld;
  logic [N-1:0][W-1:0] i_req_data;
  logic [N-1:0]        i_req_last;
  logic [N-1:0]        o_req_rdy;
  logic                o_y_vld;
  logic [W-1:0]        o_y_data;
  logic                o_y_last;
  logic [N-1:0]        o_y_src;
  logic                i_y_rdy;
  logic                o_busy;

  modport slave (
    input  i_req_vld, i_req_data, i_req_last, i_y_rdy,
    output o_req_rdy, o_y_vld, o_y_data, o_y_last, o_y_src, o_busy
  );

  modport master (
    output i_req_vld, i_req_data, i_req_last, i_y_rdy,
    input  o_req_rdy, o_y_vld, o_y_data, o_y_last, o_y_src, o_busy
  );

endinterface

// File: rtl/onehot_mux.sv
// One-hot select mux: y = data[i] where sel[i] is set; zero when sel is zero.
//   sel  : one-hot (or zero) select
//   data : N words of W bits
//   y    : selected word
module onehot_mux #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] data,
  output logic [W-1:0]        y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      y = y | (data[i] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational circular first-one finder.
//   req : request vector
//   ptr : index of the last winner; the search starts at ptr+1 mod N
//   gnt : one-hot grant, zero when req is zero
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int unsigned PW = $clog2(N);

  logic [PW:0]    sh;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [2*N-1:0] gdbl;
  logic           found;

  // Doubling the vector turns the circular search into a plain shift plus a
  // lowest-set-bit pick; the grant is rotated back the same way.
  always_comb begin
    sh    = {1'b0, ptr} + {{PW{1'b0}}, 1'b1};
    dbl   = {req, req} >> sh;
    rot   = dbl[N-1:0];
    first = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        first[i] = 1'b1;
        found    = 1'b1;
      end
    end
    gdbl = {{N{1'b0}}, first} << sh;
    gnt  = gdbl[N-1:0] | gdbl[2*N-1:N];
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing an N-input one-hot mux between N valid/ready
// requesters, holding the grant for the whole of a multi-beat packet and
// registering the selected beat into one output stage.
//   clk    : rising-edge clock
//   arst_n : asynchronous active-low reset
//   bus    : requester beats in, o_req_rdy accept strobes out, registered
//            output beat (o_y_*) with i_y_rdy backpressure, o_busy status
module mux_rr_sched
  import common_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
) (
  input logic           clk,
  input logic           arst_n,
  mux_rr_sched_if.slave bus
);

  localparam int unsigned PW = $clog2(N);

  sched_state_t   state_q, state_d;
  logic [N-1:0]   lock_q, lock_d;
  logic [PW-1:0]  ptr_q, ptr_d;

  logic           y_vld_q;
  logic [W-1:0]   y_data_q;
  logic           y_last_q;
  logic [N-1:0]   y_src_q;

  logic [N-1:0]   pick_gnt;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rdy;
  logic           adv;
  logic           acc;
  logic           sel_last;
  logic [W-1:0]   sel_data;
  logic [PW-1:0]  gnt_idx;

  rr_pick #(.N(N)) u_pick (
    .req (bus.i_req_vld),
    .ptr (ptr_q),
    .gnt (pick_gnt)
  );

  // The output stage can take a beat when it is empty or drains this cycle.
  assign adv      = ~y_vld_q | bus.i_y_rdy;
  // A locked packet owner keeps the mux even while it stalls.
  assign gnt      = (state_q == LOCKED) ? lock_q : pick_gnt;
  assign rdy      = gnt & bus.i_req_vld & {N{adv}};
  assign acc      = |rdy;
  assign sel_last = |(rdy & bus.i_req_last);

  onehot_mux #(.N(N), .W(W)) u_mux (
    .sel  (rdy),
    .data (bus.i_req_data),
    .y    (sel_data)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (rdy[i]) gnt_idx = PW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    if (acc) begin
      if (sel_last) begin
        state_d = IDLE;
        ptr_d   = gnt_idx;
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        lock_d  = rdy;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      lock_q  <= '0;
      ptr_q   <= PW'(N - 1);
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

  // Accept wins over drain, so back-to-back beats leave no bubble.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      y_vld_q  <= 1'b0;
      y_data_q <= '0;
      y_last_q <= 1'b0;
      y_src_q  <= '0;
    end else if (acc) begin
      y_vld_q  <= 1'b1;
      y_data_q <= sel_data;
      y_last_q <= sel_last;
      y_src_q  <= rdy;
    end else if (adv) begin
      y_vld_q  <= 1'b0;
    end
  end

  assign bus.o_req_rdy = rdy;
  assign bus.o_y_vld   = y_vld_q;
  assign bus.o_y_data  = y_data_q;
  assign bus.o_y_last  = y_last_q;
  assign bus.o_y_src   = y_src_q;
  assign bus.o_busy    = (state_q == LOCKED) | y_vld_q;

  a_rdy_onehot0 : assert property (@(posedge clk) disable iff (!arst_n) $onehot0(rdy));
  a_src_onehot0 : assert property (@(posedge clk) disable iff (!arst_n) $onehot0(y_src_q));
  a_src_valid   : assert property (@(posedge clk) disable iff (!arst_n)
                                   y_vld_q |-> (y_src_q != '0));
  a_lock_onehot : assert property (@(posedge clk) disable iff (!arst_n)
                                   (state_q == LOCKED) |-> $onehot(lock_q));

endmodule

// File: tb/tb_mux_rr_sched.sv
module tb_mux_rr_sched;

  localparam int N = 4;
  localparam int W = 32;

  logic clk;
  logic arst_n;

  mux_rr_sched_if #(.N(N), .W(W)) bus ();

  mux_rr_sched #(.N(N), .W(W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [N-1:0][W-1:0] din;

  // Reference model: output beat plus packet owner (-1 when none) and last winner.
  logic          m_vld;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic [N-1:0]  m_src;
  int            m_ptr;
  int            m_owner;

  // Index of the requester whose beat is taken this cycle, or -1.
  function automatic int model_pick();
    int g;
    int j;
    g = -1;
    if (m_vld && !bus.i_y_rdy) return -1;
    if (m_owner >= 0) begin
      g = m_owner;
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && bus.i_req_vld[j]) g = j;
      end
    end
    if (g >= 0 && !bus.i_req_vld[g]) g = -1;
    return g;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_vld   <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_src   <= '0;
      m_ptr   <= N - 1;
      m_owner <= -1;
    end else if (model_pick() >= 0) begin
      m_vld  <= 1'b1;
      m_data <= bus.i_req_data[model_pick()];
      m_last <= bus.i_req_last[model_pick()];
      m_src  <= N'(1) << model_pick();
      if (bus.i_req_last[model_pick()]) begin
        m_owner <= -1;
        m_ptr   <= model_pick();
      end else begin
        m_owner <= model_pick();
      end
    end else if (!m_vld || bus.i_y_rdy) begin
      m_vld <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then compare against the model.
  task automatic apply(input logic [N-1:0] vld, input logic [N-1:0] last, input logic yr);
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    bus.i_req_vld  = vld;
    bus.i_req_last = last;
    bus.i_req_data = din;
    bus.i_y_rdy    = yr;
    #1;
    g  = model_pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("model_rdy",  32'(bus.o_req_rdy), 32'(er));
    check("model_vld",  32'(bus.o_y_vld),   32'(m_vld));
    check("model_data", bus.o_y_data,       m_data);
    check("model_last", 32'(bus.o_y_last),  32'(m_last));
    check("model_src",  32'(bus.o_y_src),   32'(m_src));
    check("model_busy", 32'(bus.o_busy),    32'((m_owner >= 0) || m_vld));
  endtask

  typedef struct packed {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic        yr;
    logic [31:0] d2;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [3:0]  e_src;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [0:10];

  initial begin
    // Round-robin from reset, then a 3-beat packet from requester 2.
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 32'hD2, 4'b0001, 1'b0, 4'b0000, 32'h00};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 32'hD2, 4'b0010, 1'b1, 4'b0001, 32'hD0};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 32'hD2, 4'b0100, 1'b1, 4'b0010, 32'hD1};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 32'hD2, 4'b1000, 1'b1, 4'b0100, 32'hD2};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 32'hD2, 4'b0001, 1'b1, 4'b1000, 32'hD3};
    tbl[5]  = '{4'hF, 4'hB, 1'b1, 32'hA0, 4'b0010, 1'b1, 4'b0001, 32'hD0};
    tbl[6]  = '{4'hF, 4'hB, 1'b1, 32'hA0, 4'b0100, 1'b1, 4'b0010, 32'hD1};
    tbl[7]  = '{4'hF, 4'hB, 1'b1, 32'hA1, 4'b0100, 1'b1, 4'b0100, 32'hA0};
    tbl[8]  = '{4'hF, 4'hF, 1'b1, 32'hA2, 4'b0100, 1'b1, 4'b0100, 32'hA1};
    tbl[9]  = '{4'hF, 4'hF, 1'b1, 32'hD2, 4'b1000, 1'b1, 4'b0100, 32'hA2};
    tbl[10] = '{4'hF, 4'hF, 1'b1, 32'hD2, 4'b0001, 1'b1, 4'b1000, 32'hD3};

    arst_n         = 1'b0;
    bus.i_req_vld  = '0;
    bus.i_req_last = '0;
    bus.i_req_data = '0;
    bus.i_y_rdy    = 1'b0;
    for (int k = 0; k < N; k++) din[k] = 32'hD0 + 32'(k);

    repeat (2) @(negedge clk);
    #1;
    check("rst_vld",  32'(bus.o_y_vld),  32'd0);
    check("rst_data", bus.o_y_data,      32'd0);
    check("rst_src",  32'(bus.o_y_src),  32'd0);
    check("rst_busy", 32'(bus.o_busy),   32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i <= 10; i++) begin
      din[2] = tbl[i].d2;
      apply(tbl[i].vld, tbl[i].last, tbl[i].yr);
      check($sformatf("tbl%0d_rdy", i),  32'(bus.o_req_rdy), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_vld", i),  32'(bus.o_y_vld),   32'(tbl[i].e_vld));
      check($sformatf("tbl%0d_src", i),  32'(bus.o_y_src),   32'(tbl[i].e_src));
      check($sformatf("tbl%0d_data", i), bus.o_y_data,       tbl[i].e_data);
    end
    din[2] = 32'hD2;

    // Owner 1 stalls mid-packet; requester 0 must not be granted meanwhile.
    apply(4'b0011, 4'b0001, 1'b1);
    check("stall_lock_rdy", 32'(bus.o_req_rdy), 32'b0010);
    apply(4'b0001, 4'b0001, 1'b1);
    check("stall_b1_rdy", 32'(bus.o_req_rdy), 32'b0000);
    apply(4'b0001, 4'b0001, 1'b1);
    check("stall_b2_rdy", 32'(bus.o_req_rdy), 32'b0000);
    check("stall_b2_vld", 32'(bus.o_y_vld),   32'd0);
    apply(4'b0011, 4'b0011, 1'b1);
    check("stall_resume_rdy", 32'(bus.o_req_rdy), 32'b0010);
    apply(4'b0001, 4'b0011, 1'b1);
    check("stall_after_rdy", 32'(bus.o_req_rdy), 32'b0001);
    check("stall_after_src", 32'(bus.o_y_src),   32'b0010);

    // Backpressure: beat 0x55 held for 5 cycles, then replaced without a bubble.
    din[0] = 32'h55;
    apply(4'b0001, 4'b1111, 1'b1);
    for (int c = 0; c < 5; c++) begin
      apply(4'b1111, 4'b1111, 1'b0);
      check("bp_data", bus.o_y_data,       32'h55);
      check("bp_vld",  32'(bus.o_y_vld),   32'd1);
      check("bp_rdy",  32'(bus.o_req_rdy), 32'd0);
    end
    apply(4'b1111, 4'b1111, 1'b1);
    check("bp_release_rdy", 32'(bus.o_req_rdy), 32'b0010);
    apply(4'b0000, 4'b1111, 1'b1);
    check("bp_next_vld",  32'(bus.o_y_vld), 32'd1);
    check("bp_next_data", bus.o_y_data,     32'hD1);

    // Only requester 3 valid with ptr=3: search wraps back around to 3.
    apply(4'b1000, 4'b1111, 1'b1);
    check("wrap_first_rdy", 32'(bus.o_req_rdy), 32'b1000);
    apply(4'b1000, 4'b1111, 1'b1);
    check("wrap_rdy", 32'(bus.o_req_rdy), 32'b1000);
    apply(4'b0000, 4'b1111, 1'b1);
    check("wrap_src", 32'(bus.o_y_src), 32'b1000);
    apply(4'b0000, 4'b1111, 1'b1);
    check("drain_vld",  32'(bus.o_y_vld), 32'd0);
    check("drain_busy", 32'(bus.o_busy),  32'd0);

    // Asynchronous reset while locked on requester 1.
    apply(4'b0010, 4'b0000, 1'b1);
    check("arst_lock_rdy", 32'(bus.o_req_rdy), 32'b0010);
    apply(4'b0010, 4'b0000, 1'b1);
    #2;
    arst_n        = 1'b0;
    bus.i_req_vld = '0;
    #1;
    check("arst_vld",  32'(bus.o_y_vld), 32'd0);
    check("arst_busy", 32'(bus.o_busy),  32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    apply(4'b1111, 4'b1111, 1'b1);
    check("arst_first_rdy", 32'(bus.o_req_rdy), 32'b0001);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) din[k] = $urandom;
      apply(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_sched.md
Name: mux_rr_sched

Overview:
- Round-robin scheduler that shares a W-bit, N-input one-hot mux datapath between N valid/ready requesters.
- Issues a one-hot select to the mux each cycle.
- Holds the grant across multi-beat packets, delimited by a last flag.
- Registers the selected beat into a single output stage with a valid/ready handshake toward the downstream consumer.

Parameters:
- N, 4, number of requesters (N >= 2).
- W, 32, data width per beat.

Ports:
- clk  in  1  clock, rising-edge.
- arst_n  in  1  asynchronous active-low reset.
- i_req_vld  in  N  per-requester beat valid.
- i_req_data  in  N x W  per-requester beat data, packed [N-1:0][W-1:0].
- i_req_last  in  N  per-requester final beat of packet.
- o_req_rdy  out  N  per-requester beat accepted this cycle; at most one bit set.
- o_y_vld  out  1  output beat valid.
- o_y_data  out  W  output beat data.
- o_y_last  out  1  output beat is last of packet.
- o_y_src  out  N  one-hot source requester of the current output beat.
- i_y_rdy  in  1  downstream accepts the output beat.
- o_busy  out  1  state is LOCKED or o_y_vld is high.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous on arst_n low and released synchronously to clk.
- Values held in reset: o_y_vld=0, o_y_data=0, o_y_last=0, o_y_src=0, o_busy=0, state=IDLE, ptr=N-1.
- Effect of ptr reset: requester 0 has highest priority on the first arbitration.
- Advance condition: adv = ~o_y_vld | i_y_rdy, meaning the output stage is empty or drains this cycle.
- IDLE grant:
  - gnt = first set bit of i_req_vld, searching circularly from ptr+1 mod N.
  - Purely combinational; gnt = 0 when no request is pending.
- LOCKED grant: gnt = lock_vec, the one-hot vector of the owning requester, regardless of the other requesters' vld.
- Ready: o_req_rdy = gnt & i_req_vld & {N{adv}}.
  - Depends combinationally on i_y_rdy.
  - Requesters must not make vld depend on rdy.
- Accept: acc = |o_req_rdy. On acc, the output stage loads on the next edge:
  - o_y_data = one-hot mux of i_req_data selected by o_req_rdy;
  - o_y_last = selected i_req_last;
  - o_y_src = o_req_rdy;
  - o_y_vld = 1.
- Drain: if adv and not acc, o_y_vld goes to 0 on the next edge. Data, last and src hold their previous values.
- Latency: a beat accepted in cycle t appears on o_y_vld in cycle t+1. Throughput is one beat/cycle while i_y_rdy=1.
- State machine:
  - IDLE -> LOCKED on acc with selected last=0. lock_vec := o_req_rdy.
  - IDLE -> IDLE on acc with last=1, or on no acc.
  - LOCKED -> IDLE on acc with last=1.
  - LOCKED -> LOCKED otherwise. If the owner drops vld, bubbles are inserted and no other requester is granted.
- Pointer: ptr := index of the granted requester on every acc with last=1. It is unchanged on non-last beats and on idle cycles.
- Wrap-around: the search after ptr=N-1 starts at requester 0.
- Fairness: with all N requesting single-beat packets, each is served once every N accepted beats.
- Backpressure: while o_y_vld=1 and i_y_rdy=0, o_req_rdy=0 and all output registers hold.
- Simultaneous drain and accept (o_y_vld=1, i_y_rdy=1, acc=1): the new beat replaces the old one with no bubble.
- Mid-operation reset: asserting arst_n mid-packet aborts the packet. The output beat is lost, and the state returns to IDLE and ptr=N-1 immediately.
- Invariants, checked by assertions:
  - $onehot0(o_req_rdy);
  - $onehot0(o_y_src);
  - o_y_src != 0 whenever o_y_vld = 1;
  - in LOCKED, $onehot(lock_vec).

Decomposition:
- Shared package common_pkg (existing common package):
  - add typedef enum logic {IDLE, LOCKED} sched_state_t;
  - no other shared constants are needed.
- Sub-module rr_pick #(N):
  - combinational circular first-one finder;
  - inputs: request vector and ptr;
  - output: one-hot grant.
  - Implement it as a doubled-vector priority select.
- Data selection uses the existing one-hot mux block (N, W), driven by o_req_rdy.

Test Plan:
- Reset with all four requesters valid single-beat (last=1), i_y_rdy=1 -> o_y_src sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles starting the cycle after reset release; o_y_data matches the source.
- Requester 2 sends a 3-beat packet (0xA0, 0xA1, 0xA2; last on 3rd) while 0, 1 and 3 are valid -> three consecutive beats from src 0100, then requester 3 is served next.
- Requester 1 mid-packet drops vld for 2 cycles while requester 0 is valid -> o_req_rdy[0] stays 0, o_y_vld=0 for the bubbles, packet resumes when vld[1] returns.
- i_y_rdy=0 for 5 cycles with o_y_vld=1 and data 0x55 -> o_y_data holds 0x55, all o_req_rdy=0; on i_y_rdy=1 the next beat loads with no bubble.
- Only requester 3 valid, ptr=3 -> wrap search grants 3 (1000); with no requests, o_y_vld falls to 0 after the drain.
- arst_n pulsed low mid-packet (LOCKED on requester 1) -> o_y_vld=0 and o_busy=0 asynchronously; after release, requester 0 wins first.
